banked_dram: RTL
================

BANKED_DRAM -- requirements
Module: banked_dram

Interface
REQ-001 Parameter DATA_BYTES, default 8: bytes per bus beat; payload width is 8*DATA_BYTES.
REQ-002 Parameter MEM_BYTES, default 65536: storage size in bytes; power of two, at least DATA_BYTES.
REQ-003 Parameter ADDR_W, default 64: request address width.
REQ-004 Parameter SRC_W, default 4: source-ID width.
REQ-005 Parameter QDEPTH, default 4: request FIFO entries; power of two, at least 2.
REQ-006 Parameter RD_LAT, default 4, and WR_LAT, default 2: access delay in cycles; each at least 1.
REQ-007 Ports, one per line (name, direction, width, meaning); one clock; reset is synchronous and active-high:
  clk  in  1  clock, all state on rising edge
  reset  in  1  synchronous active-high reset
  req_valid  in  1  request present
  req_ready  out  1  FIFO can accept
  req_type  in  2  0=write, 1=read, 2/3=illegal
  req_addr  in  ADDR_W  byte address
  req_wdata  in  8*DATA_BYTES  write payload
  req_be  in  DATA_BYTES  byte enables (write only)
  req_src  in  SRC_W  requester ID
  resp_valid  out  1  response present
  resp_ready  in  1  consumer accepts
  resp_data  out  8*DATA_BYTES  read data
  resp_src  out  SRC_W  echoed req_src
  resp_err  out  1  request failed
  busy  out  1  FIFO non-empty or FSM not IDLE

Function
REQ-008 A request is accepted when req_valid && req_ready at a rising edge; it is pushed into the FIFO in order.
REQ-009 req_ready = FIFO not full; a pop and a push in the same cycle when the FIFO is full are not allowed (ready stays 0 for that cycle).
REQ-010 FSM states are IDLE, DECODE, WR_WAIT, RD_WAIT and RESP; IDLE moves to DECODE when the FIFO is non-empty and pops the head into a working register.
REQ-011 DECODE, write, in range: go to WR_WAIT, load the counter with WR_LAT-1.
REQ-012 DECODE, read, in range: go to RD_WAIT, load the counter with RD_LAT-1.
REQ-013 DECODE, otherwise: go to RESP with resp_err=1 and resp_data=0.
REQ-014 The in-range check is addr+DATA_BYTES <= MEM_BYTES, computed at ADDR_W+1 bits so it cannot wrap; out-of-range accesses never touch storage.
REQ-015 Byte order is little-endian: byte i of the payload maps to storage[addr+i] and is payload[8i+7:8i]; no alignment is required.
REQ-016 WR_WAIT, counter 0: write every byte i with be[i]=1 in one cycle, then go to IDLE. Successful writes produce no response.
REQ-017 RD_WAIT, counter 0: capture DATA_BYTES bytes into resp_data, set resp_err=0, go to RESP.
REQ-018 RESP: assert resp_valid and hold resp_data, resp_src and resp_err stable until resp_ready; on the handshake go to IDLE.
REQ-019 Bytes with be=0 are preserved, and be=0 entirely is a legal no-op write.
REQ-020 Latency with an empty FIFO and resp_ready=1:
  - read: response is valid RD_LAT+2 cycles after the accept edge;
  - write: storage is updated WR_LAT+2 cycles after the accept edge.
REQ-021 Processing is strictly in order: a read following a write to the same address returns the new data.
REQ-022 Illegal type or an out-of-range read or write yields exactly one error response; the block never halts.

Reset
REQ-023 While reset=1 at an edge:
  - FSM goes to IDLE, the FIFO is emptied and the counter is cleared;
  - outputs: resp_valid=0, resp_err=0, resp_data=0, resp_src=0, busy=0, req_ready=0.
  Reset mid-operation discards the in-flight request with no response, and a pending write is not performed.
REQ-024 Storage contents are not cleared by reset; storage is preloadable from the bench before the first request.
REQ-025 req_ready is 1 in the first cycle after reset deasserts.

Verification
REQ-026 Write addr 0x10, data 0x8877665544332211, be 0xFF, then read addr 0x10 -> one response, data 0x8877665544332211, err 0, src echoed.
REQ-027 Write addr 0x10, data all 0xAA, be 0x0F over prior 0x8877665544332211, then read -> data 0x88776655AAAAAAAA.
REQ-028 Read at addr MEM_BYTES-4 with DATA_BYTES=8 -> err 1, data 0, storage unchanged; req_type=3 -> err 1; the next valid read succeeds.
REQ-029 QDEPTH+2 back-to-back reads with resp_ready held 0 for 20 cycles -> req_ready drops after QDEPTH+1 accepts (FIFO plus working register); responses then arrive in order with correct src.
REQ-030 Reset asserted during RD_WAIT -> no response, busy=0 next cycle, and the next read completes in RD_LAT+2 cycles.

Source files
------------

// File: rtl/banked_dram_if.sv
// Request/response bus for banked_dram: in-order request channel with
// valid/ready, response channel with valid/ready, plus a busy status flag.
interface banked_dram_if #(
    parameter int DATA_BYTES = 8,
    parameter int ADDR_W     = 64,
    parameter int SRC_W      = 4
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_type;
    logic [ADDR_W-1:0]       req_addr;
    logic [8*DATA_BYTES-1:0] req_wdata;
    logic [DATA_BYTES-1:0]   req_be;
    logic [SRC_W-1:0]        req_src;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [8*DATA_BYTES-1:0] resp_data;
    logic [SRC_W-1:0]        resp_src;
    logic                    resp_err;
    logic                    busy;

    modport master (
        output req_valid, req_type, req_addr, req_wdata, req_be, req_src, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_src, resp_err, busy
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_wdata, req_be, req_src, resp_ready,
        output req_ready, resp_valid, resp_data, resp_src, resp_err, busy
    );
endinterface

// File: rtl/banked_dram.sv
// Byte-addressed memory model with a request FIFO, fixed read/write access
// latency, little-endian unaligned beats and error responses for illegal or
// out-of-range requests. Storage is never cleared by reset.
module banked_dram #(
    parameter int DATA_BYTES = 8,
    parameter int MEM_BYTES  = 65536,
    parameter int ADDR_W     = 64,
    parameter int SRC_W      = 4,
    parameter int QDEPTH     = 4,
    parameter int RD_LAT     = 4,
    parameter int WR_LAT     = 2
) (
    input logic         clk,
    input logic         reset,
    banked_dram_if.slave bus
);
    localparam int DW   = 8 * DATA_BYTES;
    localparam int MA   = $clog2(MEM_BYTES);
    localparam int QW   = $clog2(QDEPTH);
    localparam int LMAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CW   = $clog2(LMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_WR_WAIT = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [7:0]              mem [MEM_BYTES];

    logic [1:0]              f_type  [QDEPTH];
    logic [ADDR_W-1:0]       f_addr  [QDEPTH];
    logic [DW-1:0]           f_wdata [QDEPTH];
    logic [DATA_BYTES-1:0]   f_be    [QDEPTH];
    logic [SRC_W-1:0]        f_src   [QDEPTH];
    logic [QW-1:0]           wp, rp;
    logic [QW:0]             count;
    logic                    full, empty, push, pop;

    logic [2:0]              state;
    logic [CW-1:0]           cnt;
    logic [1:0]              w_type;
    logic [ADDR_W-1:0]       w_addr;
    logic [DW-1:0]           w_wdata;
    logic [DATA_BYTES-1:0]   w_be;
    logic [SRC_W-1:0]        w_src;
    logic [ADDR_W:0]         end_addr;
    logic                    in_range;
    logic [MA-1:0]           maddr;

    logic [DW-1:0]           rdata;
    logic [SRC_W-1:0]        rsrc;
    logic                    rerr;

    assign full          = (count == (QW+1)'(QDEPTH));
    assign empty         = (count == '0);
    assign bus.req_ready = !full && !reset;
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = (state == S_IDLE) && !empty;

    // One extra bit keeps the end-of-beat address from wrapping at the top of the address space
    assign end_addr = {1'b0, w_addr} + (ADDR_W+1)'(DATA_BYTES);
    assign in_range = (end_addr <= (ADDR_W+1)'(MEM_BYTES));
    assign maddr    = w_addr[MA-1:0];

    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_data  = rdata;
    assign bus.resp_src   = rsrc;
    assign bus.resp_err   = rerr;
    assign bus.busy       = !empty || (state != S_IDLE);

    // FIFO payload storage, written on an accepted request
    always_ff @(posedge clk) begin
        if (push) begin
            f_type[wp]  <= bus.req_type;
            f_addr[wp]  <= bus.req_addr;
            f_wdata[wp] <= bus.req_wdata;
            f_be[wp]    <= bus.req_be;
            f_src[wp]   <= bus.req_src;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Request sequencer: pop, decode, wait out access latency, present response
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            rdata <= '0;
            rsrc  <= '0;
            rerr  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        w_type  <= f_type[rp];
                        w_addr  <= f_addr[rp];
                        w_wdata <= f_wdata[rp];
                        w_be    <= f_be[rp];
                        w_src   <= f_src[rp];
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rsrc <= w_src;
                    if (w_type == 2'd0 && in_range) begin
                        cnt   <= CW'(WR_LAT - 1);
                        state <= S_WR_WAIT;
                    end else if (w_type == 2'd1 && in_range) begin
                        cnt   <= CW'(RD_LAT - 1);
                        state <= S_RD_WAIT;
                    end else begin
                        rerr  <= 1'b1;
                        rdata <= '0;
                        state <= S_RESP;
                    end
                end
                S_WR_WAIT: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_RD_WAIT: begin
                    if (cnt == '0) begin
                        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                            rdata[8*i +: 8] <= mem[maddr + MA'(i)];
                        end
                        rerr  <= 1'b0;
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-enabled storage write at the end of the write latency
    always_ff @(posedge clk) begin
        if (!reset && state == S_WR_WAIT && cnt == '0) begin
            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                if (w_be[i]) mem[maddr + MA'(i)] <= w_wdata[8*i +: 8];
            end
        end
    end
endmodule
